s_axi_read_ctrl: RTL and testbench
==================================

// Module: s_axi_read_ctrl
// PURPOSE
//  AXI4-Lite read slave for the DFX sequencer register file; successor read path with parametrised widths and slot count.
//  Decodes bank0 (sequencer status/counters) and bank1 (per-slot descriptors), waits on bank1 ready with timeout,
//  registers RDATA/RRESP, returns SLVERR/DECERR, and keeps a saturating read-error counter.
// PARAMETERS
//  ADDR_WIDTH           16  AXI address width (>=16; bits [ADDR_WIDTH-1:16] must be 0 else DECERR)
//  DATA_WIDTH           32  AXI data width; every field below must be <= DATA_WIDTH
//  BANK1_INDEX_WIDTH     2  slot index width (2^N slots, N <= 8)
//  BANK1_SRC_ADDR_WIDTH 32 / BANK1_SRC_SIZE_WIDTH 26 / BANK1_DST_ADDR_WIDTH 32 / BANK1_DST_SIZE_WIDTH 26  descriptor field widths
//  BANK1_STATUS_WIDTH    2  slot status width; BANK1_PROFILE_WIDTH 32 slot profile width
//  BANK0_STATUS_WIDTH    4  sequencer status width; BANK0_CNT_WIDTH = BANK1_INDEX_WIDTH counter width
//  TIMEOUT_CYCLES      256  max cycles waiting for ext_bank1_out_ready (>=1)
//  ERRCNT_WIDTH          8  width of read-error counter
// PORTS
//  clk                    in   1                     clock
//  reset                  in   1                     asynchronous, active-low reset
//  S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_WIDTH/1/1   AXI read address channel
//  S_AXI_RDATA/RRESP/RVALID/RREADY out/out/out/in DATA_WIDTH/2/1/1 AXI read data channel
//  ext_bank1_out_index    out  BANK1_INDEX_WIDTH     registered slot index
//  ext_bank1_out_req      out  1                     registered bank1 read request
//  ext_bank1_out_src_addr/src_size/des_addr/des_size/status/profile  in  field widths  slot fields
//  ext_bank1_out_ready    in   1                     slot fields valid this cycle
//  ext_bank0_out_status/mainCnt/endCnt  in  BANK0_STATUS_WIDTH/BANK0_CNT_WIDTH x2  sequencer state
//  rd_err_cnt             out  ERRCNT_WIDTH          saturating count of non-OKAY responses
// BEHAVIOUR
//  States: IDLE, B1WAIT, RESP. Reset (async, low): IDLE, ARREADY=1, RVALID=0, RDATA=0, RRESP=0, req=0, index=0, rd_err_cnt=0, timer=0.
//  ARREADY = (state==IDLE), independent of ARVALID. Handshake on ARVALID&&ARREADY; ARADDR decoded that edge.
//  Decode (addr[1:0] ignored): [15:14]=00 bank0, reg=addr[13:6]: 1 status, 2 mainCnt, 3 endCnt, 0 -> 0 OKAY, >3 -> DECERR.
//   [15:14]=01 bank1: slot=addr[6+N-1:6], addr[13:6+N] nonzero -> DECERR; word=addr[5:2]: 0 src_addr,1 src_size,
//   2 des_addr,3 des_size,4 status,5 profile, 6..15 -> DECERR. [15:14]=1x or high bits set -> DECERR.
//  All fields zero-extended to DATA_WIDTH. DECERR/SLVERR responses carry RDATA=0.
//  IDLE->RESP (bank0, DECERR): RDATA/RRESP registered at AR edge; RVALID high next cycle (latency 1).
//  IDLE->B1WAIT (valid bank1): index latched, req=1 from next cycle, timer cleared.
//  B1WAIT: each cycle req=1 && ready=1 -> capture field, RRESP=OKAY, req=0, ->RESP. Ready sampled only while req=1.
//   timer reaches TIMEOUT_CYCLES without ready -> RRESP=SLVERR(2'b10), RDATA=0, req=0, ->RESP.
//   ready in the same cycle the timer expires wins (OKAY).
//  RESP: RVALID=1; RDATA/RRESP stable until RREADY. RVALID&&RREADY -> IDLE (ARREADY high the following cycle; no back-to-back).
//  rd_err_cnt increments by 1 on each R handshake with RRESP!=OKAY; saturates at all-ones.
//  index holds last value outside B1WAIT. Reset mid-transaction aborts it; no response issued afterwards.
// TESTING
//  Read 0x0040 with status=4'hA, RREADY=1 -> RVALID at cycle+1, RDATA=0x0000000A, RRESP=0, ARREADY low 1 cycle.
//  Read 0x4094 (slot 2, word 5), ready after 3 cycles, profile=0xDEADBEEF -> index=2, req 3 cycles, RDATA=0xDEADBEEF OKAY.
//  Read 0x4000, ready never, TIMEOUT_CYCLES=16 -> req 16 cycles, RRESP=2'b10, RDATA=0, rd_err_cnt=1.
//  Reads 0x8000 and 0x0100 -> both RRESP=2'b11, RDATA=0; rd_err_cnt=2; ERRCNT_WIDTH=2 after 5 errors -> 3.
//  RREADY held low 10 cycles in RESP, ARVALID high with new addr -> RDATA/RRESP stable, ARREADY=0 until R handshake.
//  Reset asserted during B1WAIT -> req=0, RVALID=0, state IDLE; next read 0x0080 returns mainCnt normally.

Source files
------------

// File: rtl/s_axi_read_ctrl_if.sv
// AXI4-Lite read-only channel bundle (AR + R) for the DFX sequencer register file.
interface s_axi_read_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/s_axi_read_ctrl.sv
// AXI4-Lite read slave: bank0 sequencer state, bank1 slot descriptors fetched with a
// request/ready handshake and timeout, registered response and saturating error counter.
module s_axi_read_ctrl #(
  parameter int unsigned ADDR_WIDTH           = 16,
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned BANK1_INDEX_WIDTH    = 2,
  parameter int unsigned BANK1_SRC_ADDR_WIDTH = 32,
  parameter int unsigned BANK1_SRC_SIZE_WIDTH = 26,
  parameter int unsigned BANK1_DST_ADDR_WIDTH = 32,
  parameter int unsigned BANK1_DST_SIZE_WIDTH = 26,
  parameter int unsigned BANK1_STATUS_WIDTH   = 2,
  parameter int unsigned BANK1_PROFILE_WIDTH  = 32,
  parameter int unsigned BANK0_STATUS_WIDTH   = 4,
  parameter int unsigned BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES       = 256,
  parameter int unsigned ERRCNT_WIDTH         = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  s_axi_read_ctrl_if.slave                s_axi,
  output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
  output logic                            ext_bank1_out_req,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_out_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_out_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_out_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_out_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_out_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_out_profile,
  input  logic                            ext_bank1_out_ready,
  input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_out_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_out_mainCnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_out_endCnt,
  output logic [ERRCNT_WIDTH-1:0]         rd_err_cnt
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StB1Wait, StResp} state_e;

  state_e                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [BANK1_INDEX_WIDTH-1:0] index_q, index_d;
  logic                         req_q, req_d;
  logic [2:0]                   word_q, word_d;
  logic [TimerW-1:0]            timer_q, timer_d;
  logic [ERRCNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            reg_sel;
  logic [3:0]            word_sel;
  logic                  dec_bank1, dec_err;
  logic [DATA_WIDTH-1:0] dec_data, field_data;
  logic                  unused_addr;

  assign addr        = s_axi.S_AXI_ARADDR;
  assign reg_sel     = addr[13:6];
  assign word_sel    = addr[5:2];
  assign unused_addr = ^addr[1:0];

  always_comb begin
    dec_bank1 = 1'b0;
    dec_err   = 1'b0;
    dec_data  = '0;
    if ((|(addr >> 16)) || addr[15]) begin
      dec_err = 1'b1;
    end else if (!addr[14]) begin
      case (reg_sel)
        8'd0:    dec_data = '0;
        8'd1:    dec_data = DATA_WIDTH'(ext_bank0_out_status);
        8'd2:    dec_data = DATA_WIDTH'(ext_bank0_out_mainCnt);
        8'd3:    dec_data = DATA_WIDTH'(ext_bank0_out_endCnt);
        default: dec_err  = 1'b1;
      endcase
    end else if (((reg_sel >> BANK1_INDEX_WIDTH) != 8'd0) || (word_sel > 4'd5)) begin
      dec_err = 1'b1;
    end else begin
      dec_bank1 = 1'b1;
    end
  end

  always_comb begin
    case (word_q)
      3'd0:    field_data = DATA_WIDTH'(ext_bank1_out_src_addr);
      3'd1:    field_data = DATA_WIDTH'(ext_bank1_out_src_size);
      3'd2:    field_data = DATA_WIDTH'(ext_bank1_out_des_addr);
      3'd3:    field_data = DATA_WIDTH'(ext_bank1_out_des_size);
      3'd4:    field_data = DATA_WIDTH'(ext_bank1_out_status);
      3'd5:    field_data = DATA_WIDTH'(ext_bank1_out_profile);
      default: field_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    index_d   = index_q;
    req_d     = req_q;
    word_d    = word_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (s_axi.S_AXI_ARVALID) begin
          if (dec_bank1) begin
            index_d = addr[6 +: BANK1_INDEX_WIDTH];
            word_d  = word_sel[2:0];
            req_d   = 1'b1;
            timer_d = '0;
            state_d = StB1Wait;
          end else begin
            rdata_d = dec_err ? '0 : dec_data;
            rresp_d = dec_err ? RespDecErr : RespOkay;
            state_d = StResp;
          end
        end
      end
      StB1Wait: begin
        // Ready is checked before the timeout so a late ready still wins.
        if (req_q && ext_bank1_out_ready) begin
          rdata_d = field_data;
          rresp_d = RespOkay;
          req_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          rresp_d = RespSlvErr;
          req_d   = 1'b0;
          state_d = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (s_axi.S_AXI_RREADY) begin
          state_d = StIdle;
          if ((rresp_q != RespOkay) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      index_q   <= '0;
      req_q     <= 1'b0;
      word_q    <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      index_q   <= index_d;
      req_q     <= req_d;
      word_q    <= word_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_axi.S_AXI_ARREADY = (state_q == StIdle);
  assign s_axi.S_AXI_RVALID  = (state_q == StResp);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign ext_bank1_out_index = index_q;
  assign ext_bank1_out_req   = req_q;
  assign rd_err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_s_axi_read_ctrl.sv
// Directed bench for s_axi_read_ctrl: bank0/bank1 reads, timeout, decode errors,
// response back-pressure, error-counter saturation and mid-transaction reset.
module tb_s_axi_read_ctrl;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  b1_index;
  logic        b1_req;
  logic [31:0] b1_src_addr;
  logic [25:0] b1_src_size;
  logic [31:0] b1_des_addr;
  logic [25:0] b1_des_size;
  logic [1:0]  b1_status;
  logic [31:0] b1_profile;
  logic        b1_ready;
  logic [3:0]  b0_status;
  logic [1:0]  b0_main_cnt;
  logic [1:0]  b0_end_cnt;
  logic [1:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int reqs;

  s_axi_read_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  s_axi_read_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16),
    .ERRCNT_WIDTH  (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .s_axi                 (axi),
    .ext_bank1_out_index   (b1_index),
    .ext_bank1_out_req     (b1_req),
    .ext_bank1_out_src_addr(b1_src_addr),
    .ext_bank1_out_src_size(b1_src_size),
    .ext_bank1_out_des_addr(b1_des_addr),
    .ext_bank1_out_des_size(b1_des_size),
    .ext_bank1_out_status  (b1_status),
    .ext_bank1_out_profile (b1_profile),
    .ext_bank1_out_ready   (b1_ready),
    .ext_bank0_out_status  (b0_status),
    .ext_bank0_out_mainCnt (b0_main_cnt),
    .ext_bank0_out_endCnt  (b0_end_cnt),
    .rd_err_cnt            (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [AW-1:0] addr);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    chk("arready_before_ar", axi.S_AXI_ARREADY, 1);
    tick();
    axi.S_AXI_ARVALID = 1'b0;
  endtask

  // Counts req-high cycles until the slave leaves B1WAIT; ready pulses on cycle ready_at.
  task automatic b1_wait(input int ready_at, output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (!b1_req) break;
      n++;
      b1_ready = (n == ready_at);
      tick();
      b1_ready = 1'b0;
    end
  endtask

  task automatic decerr(input string tag, input logic [AW-1:0] addr, input logic [1:0] cnt_exp);
    ar(addr);
    chk({tag, "_rvalid"}, axi.S_AXI_RVALID, 1);
    chk({tag, "_rresp"}, axi.S_AXI_RRESP, 2'b11);
    chk({tag, "_rdata"}, axi.S_AXI_RDATA, 0);
    tick();
    chk({tag, "_errcnt"}, err_cnt, cnt_exp);
  endtask

  initial begin
    reset             = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b1;
    b1_src_addr = 32'h1111_2222;
    b1_src_size = 26'h3AB_CDEF;
    b1_des_addr = 32'h3333_4444;
    b1_des_size = 26'h012_3456;
    b1_status   = 2'b10;
    b1_profile  = 32'hDEAD_BEEF;
    b1_ready    = 1'b0;
    b0_status   = 4'hA;
    b0_main_cnt = 2'd3;
    b0_end_cnt  = 2'd1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", axi.S_AXI_ARREADY, 1);
    chk("rst_rvalid", axi.S_AXI_RVALID, 0);
    chk("rst_rdata", axi.S_AXI_RDATA, 0);
    chk("rst_rresp", axi.S_AXI_RRESP, 0);
    chk("rst_req", b1_req, 0);
    chk("rst_index", b1_index, 0);
    chk("rst_errcnt", err_cnt, 0);
    reset = 1'b1;
    tick();

    // bank0 status, latency 1
    ar(20'h00040);
    chk("b0st_rvalid", axi.S_AXI_RVALID, 1);
    chk("b0st_rdata", axi.S_AXI_RDATA, 32'h0000_000A);
    chk("b0st_rresp", axi.S_AXI_RRESP, 0);
    chk("b0st_arready", axi.S_AXI_ARREADY, 0);
    tick();
    chk("b0st_rvalid_done", axi.S_AXI_RVALID, 0);
    chk("b0st_arready_back", axi.S_AXI_ARREADY, 1);

    // slot 2 profile, ready on the third req cycle
    ar(20'h04094);
    chk("prof_index", b1_index, 2);
    chk("prof_rvalid_wait", axi.S_AXI_RVALID, 0);
    b1_wait(3, reqs);
    chk("prof_req_cycles", reqs, 3);
    chk("prof_rvalid", axi.S_AXI_RVALID, 1);
    chk("prof_rdata", axi.S_AXI_RDATA, 32'hDEAD_BEEF);
    chk("prof_rresp", axi.S_AXI_RRESP, 0);
    tick();
    chk("prof_errcnt", err_cnt, 0);

    // slot 1 src_size, ready arrives in the very cycle the timer expires
    ar(20'h04044);
    chk("edge_index", b1_index, 1);
    b1_wait(16, reqs);
    chk("edge_req_cycles", reqs, 16);
    chk("edge_rresp", axi.S_AXI_RRESP, 0);
    chk("edge_rdata", axi.S_AXI_RDATA, 32'h03AB_CDEF);
    tick();

    // slot 0 src_addr, ready never comes
    ar(20'h04000);
    chk("to_index", b1_index, 0);
    b1_wait(0, reqs);
    chk("to_req_cycles", reqs, 16);
    chk("to_rvalid", axi.S_AXI_RVALID, 1);
    chk("to_rresp", axi.S_AXI_RRESP, 2'b10);
    chk("to_rdata", axi.S_AXI_RDATA, 0);
    tick();
    chk("to_errcnt", err_cnt, 1);

    ar(20'h00000);
    chk("reg0_rdata", axi.S_AXI_RDATA, 0);
    chk("reg0_rresp", axi.S_AXI_RRESP, 0);
    tick();
    ar(20'h00040);
    tick();

    decerr("bank2", 20'h08000, 2'd2);
    decerr("b0reg4", 20'h00100, 2'd3);
    decerr("hibits", 20'h10040, 2'd3);
    decerr("b1word6", 20'h04018, 2'd3);
    decerr("b1slothi", 20'h04100, 2'd3);

    // back-pressure: response held, new AR ignored
    axi.S_AXI_RREADY = 1'b0;
    ar(20'h000C0);
    axi.S_AXI_ARADDR  = 20'h00040;
    axi.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rvalid", axi.S_AXI_RVALID, 1);
      chk("bp_rdata", axi.S_AXI_RDATA, 1);
      chk("bp_rresp", axi.S_AXI_RRESP, 0);
      chk("bp_arready", axi.S_AXI_ARREADY, 0);
      tick();
    end
    axi.S_AXI_RREADY  = 1'b1;
    axi.S_AXI_ARVALID = 1'b0;
    tick();
    chk("bp_rvalid_done", axi.S_AXI_RVALID, 0);
    chk("bp_arready_back", axi.S_AXI_ARREADY, 1);

    // reset while waiting on slot 1
    ar(20'h04040);
    tick();
    chk("mr_req_before", b1_req, 1);
    chk("mr_index_before", b1_index, 1);
    reset = 1'b0;
    #2;
    chk("mr_req", b1_req, 0);
    chk("mr_rvalid", axi.S_AXI_RVALID, 0);
    chk("mr_arready", axi.S_AXI_ARREADY, 1);
    chk("mr_index", b1_index, 0);
    chk("mr_errcnt", err_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("mr_no_resp", axi.S_AXI_RVALID, 0);
    chk("mr_no_req", b1_req, 0);
    ar(20'h00080);
    chk("mr_main_rvalid", axi.S_AXI_RVALID, 1);
    chk("mr_main_rdata", axi.S_AXI_RDATA, 3);
    chk("mr_main_rresp", axi.S_AXI_RRESP, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
